// File: rtl/cmp_arbiter.sv
// Shared 32-bit comparator with round-robin request arbitration.
// Requests go through arbitration, an operand register, a compare, and a tagged result register.
module magcompare32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt,
    output logic        gt
);
    assign lt = (a < b);
    assign gt = (a > b);
endmodule

module cmp_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_signed,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic                 resp_lt,
    output logic                 resp_eq,
    output logic                 resp_gt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

    stage_t         s1_state, s1_next;
    stage_t         s2_state, s2_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           sel_signed;
    logic           s1_valid;
    logic           adv1;
    logic           adv2;
    logic           accept;
    logic           load2;
    logic [31:0]    s1_a;
    logic [31:0]    s1_b;
    logic [IDW-1:0] s1_id;
    logic           cmp_lt;
    logic           cmp_gt;

    assign s1_valid   = (s1_state == FULL);
    assign resp_valid = (s2_state == FULL);
    assign adv2       = !resp_valid || resp_ready;
    assign adv1       = !s1_valid || adv2;
    assign accept     = found && adv1 && !reset;
    assign load2      = s1_valid && adv2;

    // Search starts one past the last grant, so the previous winner has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        sel_signed = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (winner == IDW'(j)) begin
                sel_a      = req_a[32*j +: 32];
                sel_b      = req_b[32*j +: 32];
                sel_signed = req_signed[j];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_state <= EMPTY;
            s2_state <= EMPTY;
        end else begin
            s1_state <= s1_next;
            s2_state <= s2_next;
        end
    end

    always_comb begin
        s1_next = s1_state;
        s2_next = s2_state;
        if (accept) begin
            s1_next = FULL;
        end else if (load2) begin
            s1_next = EMPTY;
        end
        if (load2) begin
            s2_next = FULL;
        end else if (resp_ready) begin
            s2_next = EMPTY;
        end
    end

    magcompare32 u_cmp (
        .a  (s1_a),
        .b  (s1_b),
        .lt (cmp_lt),
        .gt (cmp_gt)
    );

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= IDW'(NREQ - 1);
            s1_a    <= '0;
            s1_b    <= '0;
            s1_id   <= '0;
            resp_id <= '0;
            resp_lt <= 1'b0;
            resp_eq <= 1'b0;
            resp_gt <= 1'b0;
        end else begin
            if (accept) begin
                ptr   <= winner;
                s1_a  <= {sel_a[31] ^ sel_signed, sel_a[30:0]};
                s1_b  <= {sel_b[31] ^ sel_signed, sel_b[30:0]};
                s1_id <= winner;
            end
            if (load2) begin
                resp_id <= s1_id;
                resp_lt <= cmp_lt;
                resp_gt <= cmp_gt;
                resp_eq <= !(cmp_lt || cmp_gt);
            end
        end
    end
endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: directed scenarios followed by randomized traffic.
module tb_cmp_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a = '0;
    logic [32*NREQ-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_signed = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [IDW-1:0]      resp_id;
    logic                resp_lt, resp_eq, resp_gt;

    cmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_lt    (resp_lt),
        .resp_eq    (resp_eq),
        .resp_gt    (resp_gt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [2:0]     res;
    } exp_t;

    exp_t            q[$];
    int              vectors = 0;
    int              miscompares = 0;
    int              mptr = NREQ - 1;
    int              pick;
    int              w;
    logic            stall = 1'b0;
    logic            rst_prev = 1'b0;
    logic [5:0]      prev_resp;
    logic [NREQ-1:0] exp_ready;
    exp_t            e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result as {lt, eq, gt}.
    function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
        return {a < b, a == b, a > b};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7fff_ffff;
            3: return 32'hffff_ffff;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: a full pipeline (two results held) only accepts when the output drains.
    always @(negedge clk) begin
        if (reset) begin
            chk("ready_in_reset", req_ready, '0);
            if (rst_prev) chk("reset_state", {resp_valid, resp_id, resp_lt, resp_eq, resp_gt}, '0);
            q.delete();
            mptr  = NREQ - 1;
            stall = 1'b0;
        end else begin
            pick      = rr_pick(req_valid, mptr);
            exp_ready = '0;
            if (pick >= 0 && (q.size() < 2 || resp_ready)) exp_ready[pick] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            if (stall) chk("resp_hold", {resp_valid, resp_id, resp_lt, resp_eq, resp_gt}, prev_resp);
            if (resp_valid) begin
                chk("resp_onehot", $countones({resp_lt, resp_eq, resp_gt}), 1);
                if (resp_ready) begin
                    chk("resp_pending", q.size() != 0, 1'b1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("resp", {resp_id, resp_lt, resp_eq, resp_gt}, {e.id, e.res});
                    end
                end
            end
            stall     = resp_valid && !resp_ready;
            prev_resp = {resp_valid, resp_id, resp_lt, resp_eq, resp_gt};
            if ((req_valid & req_ready) != '0) begin
                w = 0;
                for (int k = 0; k < NREQ; k++) if (req_valid[k] && req_ready[k]) w = k;
                e.id  = IDW'(w);
                e.res = ref_cmp(req_a[w*32 +: 32], req_b[w*32 +: 32], req_signed[w]);
                q.push_back(e);
                mptr = w;
            end
        end
        rst_prev = reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset     = 1'b1;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic one_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [2:0] exp3, input string nm);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        req_valid            = oh;
        req_a[i*32 +: 32]    = a;
        req_b[i*32 +: 32]    = b;
        req_signed[i]        = s;
        @(negedge clk);
        chk({nm, "_grant"}, req_ready, oh);
        step();
        req_valid = '0;
        @(negedge clk);
        chk({nm, "_lat1"}, resp_valid, 1'b0);
        @(negedge clk);
        chk({nm, "_result"}, {resp_valid, resp_id, resp_lt, resp_eq, resp_gt}, {1'b1, IDW'(i), exp3});
        repeat (3) step();
    endtask

    initial begin
        int n;
        logic [NREQ-1:0] g;
        logic [31:0] a, b;

        do_reset();
        repeat (6) step();
        one_req(0, 32'h0000_0005, 32'h0000_0009, 1'b0, 3'b100, "unsigned_lt");
        one_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, "signed_neg");
        one_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, "unsigned_big");
        one_req(1, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b010, "signed_eq");
        one_req(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 3'b010, "unsigned_eq");

        // Fairness: all requesters held high, one grant and one result per cycle.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = $urandom();
            req_b[i*32 +: 32] = $urandom();
        end
        req_signed = 4'b0101;
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, 4'b0001 << (k % 4));
            if (k >= 2) chk("rr_resp", {resp_valid, resp_id}, {1'b1, IDW'((k - 2) % 4)});
            step();
        end
        req_valid = '0;
        repeat (4) step();

        // Backpressure: requester 2 streams against a stalled consumer.
        do_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b0100;
        n = 0;
        g = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (req_ready[2]) n++;
            g = req_ready;
            step();
            req_a[2*32 +: 32] = $urandom();
            req_b[2*32 +: 32] = $urandom();
        end
        chk("bp_accepts", n, 2);
        chk("bp_blocked", g, '0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (5) step();

        // Reset while requester 3 is in flight.
        do_reset();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("mid_grant3", req_ready, 4'b1000);
        step();
        reset     = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("mid_noresp0", resp_valid, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_prio0", req_ready, 4'b0001);
        chk("mid_noresp1", resp_valid, 1'b0);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("mid_noresp2", resp_valid, 1'b0);
        @(negedge clk);
        chk("mid_first_id", {resp_valid, resp_id}, {1'b1, IDW'(0)});
        repeat (4) step();

        // Random traffic with occasional resets.
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            step();
            reset = ($urandom_range(0, 999) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (g[i] || !req_valid[i] || $urandom_range(0, 15) == 0) begin
                    req_valid[i]      = ($urandom_range(0, 2) != 0);
                    a                 = rnd_word();
                    b                 = ($urandom_range(0, 3) == 0) ? a : rnd_word();
                    req_a[i*32 +: 32] = a;
                    req_b[i*32 +: 32] = b;
                    req_signed[i]     = 1'($urandom_range(0, 1));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shared-comparator arbiter: lets up to NREQ requesters (branch unit, set-less-than unit, and similar) time-share one 32-bit magnitude comparator (magcompare32) instead of each instantiating its own. Requests are granted round-robin, their operands are registered, compared in a second stage and returned as a tagged, registered LT/EQ/GT result with a valid/ready handshake. The block performs signed or unsigned comparison per request.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, 2: response tag width, must equal clog2(NREQ)
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  request accepted this cycle, at most one bit set
- req_a  in  32*NREQ  operand A, requester i on bits [32*i+31:32*i]
- req_b  in  32*NREQ  operand B, same packing
- req_signed  in  NREQ  1 = two's-complement compare, 0 = unsigned
- resp_valid  out  1  result present
- resp_ready  in  1  consumer takes result
- resp_id  out  IDW  index of the requester that issued the result
- resp_lt / resp_eq / resp_gt  out  1 each  A<B / A==B / A>B; exactly one is set while resp_valid=1

## Operation
- Stages:
  - S0, arbitration: combinational round-robin pick among req_valid.
  - S1, operand register: s1_valid, s1_a, s1_b, s1_id.
  - S2, result register: resp_valid, resp_id, lt/eq/gt.
- Round-robin: a pointer holds the last granted index. Search starts at pointer+1 modulo NREQ; the first set req_valid wins. The pointer updates to the winner only on an accepted transfer.
- Advance conditions:
  - adv2 = !resp_valid | resp_ready.
  - adv1 = !s1_valid | adv2.
  - req_ready[winner] = adv1. All other req_ready bits = 0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Signed mode: bit 31 of both operands is inverted when captured into S1; the comparator always operates unsigned. Unsigned mode captures the operands unchanged.
- The comparator is driven only from S1 registers, never from request ports.
- S2 loads the comparator outputs when s1_valid & adv2. resp_eq = !(lt|gt).
- S2 holds all response outputs stable while resp_valid & !resp_ready.
- Register state machine per stage: EMPTY -> FULL on load; FULL -> EMPTY when drained with no new load; FULL -> FULL when drained and reloaded in the same cycle.

## Timing
- Reset values:
  - req_ready combinational, 0 while reset is asserted.
  - resp_valid=0, resp_id=0, resp_lt=resp_eq=resp_gt=0.
  - s1_valid=0.
  - Pointer = NREQ-1, so requester 0 has highest priority at the first arbitration.
- Latency: a request accepted in cycle t has resp_valid=1 in cycle t+2 if resp_ready stayed high.
- Throughput: one result per cycle when resp_ready=1 continuously; no bubbles.
- Backpressure:
  - resp_ready=0 with S2 full: S1 may still fill once.
  - Once S1 and S2 are both full, all req_ready bits = 0.
  - When resp_ready returns to 1, S2 takes S1 in that same cycle and a new request is accepted in that same cycle.
- Simultaneous requests: exactly one grant per cycle. Losing requesters hold their request and are served within NREQ-1 further grants.
- Requester drops req_valid before grant: no transfer, pointer unchanged.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is issued for them. Reset does not need any idle condition.

## Test plan
- Single unsigned request: req 0 with A=0x00000005, B=0x00000009 accepted in cycle 10 -> resp_valid in cycle 12 with id=0, lt=1, eq=0, gt=0.
- Signed vs unsigned: req 1 with A=0xFFFFFFFF, B=0x00000001. With signed=1 -> lt=1. With signed=0 -> gt=1. Equal operands 0x80000000 -> eq=1 in both modes.
- Fairness: all 4 req_valid held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; resp_id follows the same order two cycles later, one result per cycle.
- Backpressure: resp_ready=0 for 5 cycles while req 2 streams -> exactly two requests accepted, then req_ready=0. The response holds stable. On release, ids resume in order with no loss or duplication.
- Reset mid-flight: assert reset one cycle after accepting req 3 -> no resp_valid for it. After reset, req 0 and req 3 request together -> req 0 is granted first.
- Random: 10k random operands, modes and requester patterns -> every response matches a reference model ($signed/$unsigned comparison); exactly one of lt/eq/gt is set.
